// File: rtl/z16_pkg.sv
// Shared Z16 constants and types used by the data-memory arbiter and its helpers.
package z16_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/z16_rr_pick2.sv
// Two-way winner select: round-robin on ties (PRIO_MODE=0) or fixed port-0 priority (PRIO_MODE=1).
module z16_rr_pick2 #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_rr_ptr,
  output logic o_valid_c,
  output logic o_winner_c
);
  import z16_pkg::*;

  always_comb begin
    o_valid_c  = i_req0 | i_req1;
    o_winner_c = PORT_CPU;
    if (PRIO_MODE != 0) begin
      o_winner_c = i_req0 ? PORT_CPU : PORT_DBG;
    end else if (i_req0 && i_req1) begin
      o_winner_c = i_rr_ptr;
    end else begin
      o_winner_c = i_req1 ? PORT_DBG : PORT_CPU;
    end
  end

endmodule

// File: rtl/z16_dmem_arbiter.sv
// Arbitrates the single-port Z16 data memory between the CPU port (0) and the loader/debug port (1).
// One access per IDLE -> ACCESS -> RESP pass; bad addresses are answered with err and never reach memory.
module z16_dmem_arbiter #(
  parameter int unsigned DATA_W    = z16_pkg::DATA_W,
  parameter int unsigned ADDR_W    = z16_pkg::ADDR_W,
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_p0_req,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic              i_p0_wen,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic              o_p0_ack,
  output logic              o_p0_err,
  output logic [DATA_W-1:0] o_p0_rdata,
  input  logic              i_p1_req,
  input  logic [ADDR_W-1:0] i_p1_addr,
  input  logic              i_p1_wen,
  input  logic [DATA_W-1:0] i_p1_wdata,
  output logic              o_p1_ack,
  output logic              o_p1_err,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_wen,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);
  import z16_pkg::*;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_BYTES - 2);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              rr_q, rr_d;
  logic              p0_ack_q, p0_ack_d;
  logic              p1_ack_q, p1_ack_d;
  logic              p0_err_q, p0_err_d;
  logic              p1_err_q, p1_err_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_wen_q, mem_wen_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;

  logic              pick_valid_c;
  logic              pick_winner_c;
  logic              win_wen_c;
  logic [ADDR_W-1:0] win_addr_c;
  logic [DATA_W-1:0] win_wdata_c;
  logic              addr_ok_c;
  logic              load_ok_c;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[0] == 1'b0) && (32'(a) <= LAST_ADDR);
  endfunction

  z16_rr_pick2 #(
    .PRIO_MODE(PRIO_MODE)
  ) u_pick (
    .i_req0    (i_p0_req),
    .i_req1    (i_p1_req),
    .i_rr_ptr  (rr_q),
    .o_valid_c (pick_valid_c),
    .o_winner_c(pick_winner_c)
  );

  // Payload of the port that wins this IDLE cycle.
  always_comb begin
    win_wen_c   = i_p0_wen;
    win_addr_c  = i_p0_addr;
    win_wdata_c = i_p0_wdata;
    if (pick_winner_c == PORT_DBG) begin
      win_wen_c   = i_p1_wen;
      win_addr_c  = i_p1_addr;
      win_wdata_c = i_p1_wdata;
    end
  end

  // mem_addr_q holds the owner's address through ACCESS; a latched wen of 0 on a good address is a load.
  assign addr_ok_c = addr_ok(mem_addr_q);
  assign load_ok_c = addr_ok_c && !mem_wen_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    p0_ack_d    = 1'b0;
    p1_ack_d    = 1'b0;
    p0_err_d    = 1'b0;
    p1_err_d    = 1'b0;
    p0_rdata_d  = p0_rdata_q;
    p1_rdata_d  = p1_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wen_d   = 1'b0;
    mem_wdata_d = mem_wdata_q;
    busy_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid_c) begin
          owner_d     = pick_winner_c;
          mem_addr_d  = win_addr_c;
          mem_wdata_d = win_wdata_c;
          mem_wen_d   = win_wen_c && addr_ok(win_addr_c);
          busy_d      = 1'b1;
          state_d     = ST_ACCESS;
          if ((PRIO_MODE == 0) && i_p0_req && i_p1_req) begin
            rr_d = ~pick_winner_c;
          end
        end
      end
      ST_ACCESS: begin
        busy_d  = 1'b1;
        state_d = ST_RESP;
        if (owner_q == PORT_CPU) begin
          p0_ack_d = 1'b1;
          p0_err_d = ~addr_ok_c;
          if (load_ok_c) p0_rdata_d = i_mem_rdata;
        end else begin
          p1_ack_d = 1'b1;
          p1_err_d = ~addr_ok_c;
          if (load_ok_c) p1_rdata_d = i_mem_rdata;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= PORT_CPU;
      rr_q        <= PORT_CPU;
      p0_ack_q    <= 1'b0;
      p1_ack_q    <= 1'b0;
      p0_err_q    <= 1'b0;
      p1_err_q    <= 1'b0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
      mem_addr_q  <= '0;
      mem_wen_q   <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      p0_ack_q    <= p0_ack_d;
      p1_ack_q    <= p1_ack_d;
      p0_err_q    <= p0_err_d;
      p1_err_q    <= p1_err_d;
      p0_rdata_q  <= p0_rdata_d;
      p1_rdata_q  <= p1_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wen_q   <= mem_wen_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign o_p0_ack    = p0_ack_q;
  assign o_p1_ack    = p1_ack_q;
  assign o_p0_err    = p0_err_q;
  assign o_p1_err    = p1_err_q;
  assign o_p0_rdata  = p0_rdata_q;
  assign o_p1_rdata  = p1_rdata_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_busy      = busy_q;
  // Reset in ACCESS must suppress the write that would land on the same edge.
  assign o_mem_wen   = mem_wen_q & ~i_rst;

endmodule
